mux_arbiter: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects either a software-fixed channel or, in round-robin mode, the next requesting channel. It holds the winner in an output register until downstream accepts it. It sits between the register-file/ALU result sources and the shared datapath bus of the processor, replacing the fixed 16-bit 8:1 combinational mux where sources become independently timed.

---
 rtl/mux_arbiter.sv | 101 ++++++++++
 tb/tb_mux_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Registered N-channel, W-bit multiplexer with valid/ready on every input and on the output.
// Selection is either a software-fixed channel or round-robin starting from a rotating pointer.
module mux_arbiter #(
    parameter int W = 16,
    parameter int N = 8,
    localparam int SW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [N*W-1:0]    indata,
    input  logic [N-1:0]      invalid,
    output logic [N-1:0]      inready,
    output logic [W-1:0]      outdata,
    output logic [SW-1:0]     outsrc,
    output logic              outvalid,
    input  logic              outready,
    output logic [15:0]       count
);

    logic [SW-1:0]   ptr;
    logic [SW-1:0]   cand;
    logic [SW-1:0]   off;
    logic [SW:0]     sum;
    logic            found;
    logic            load;
    logic            grant;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [W-1:0]    cand_data;

    // Rotating the request vector by ptr turns the wrap-around scan into a plain priority pick.
    assign dbl = {invalid, invalid} >> ptr;
    assign rot = dbl[N-1:0];

    // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        off   = '0;
        sum   = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && invalid[i]) begin
                    found = 1'b1;
                    cand  = SW'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (rot[i]) begin
                    found = 1'b1;
                    off   = SW'(i);
                end
            end
            sum = {1'b0, ptr} + {1'b0, off};
            if (sum >= (SW+1)'(N)) begin
                sum = sum - (SW+1)'(N);
            end
            cand = sum[SW-1:0];
        end
    end

    assign load = !outvalid || outready;
    // NOTE: gating with reset_n keeps inready low while reset is held, even though the empty register looks loadable.
    assign grant = found && load && reset_n;

    always_comb begin
        inready   = '0;
        cand_data = '0;
        for (int i = 0; i < N; i++) begin
            inready[i] = grant && (cand == SW'(i));
            if (cand == SW'(i)) begin
                cand_data = indata[i*W +: W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outdata  <= '0;
            outsrc   <= '0;
            outvalid <= 1'b0;
            ptr      <= '0;
            count    <= '0;
        end else if (grant) begin
            outdata  <= cand_data;
            outsrc   <= cand;
            outvalid <= 1'b1;
            count    <= count + 16'd1;
            if (mode) begin
                ptr <= (cand == SW'(N - 1)) ? '0 : cand + SW'(1);
            end
        end else if (outvalid && outready) begin
            outvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomised and directed bench for mux_arbiter against a queue-free behavioural model.
// A second instance with N = 6 covers the out-of-range fixed select.
module tb_mux_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mode;
    logic [2:0]   sel;
    logic [127:0] indata;
    logic [7:0]   invalid;
    logic [7:0]   inready;
    logic [15:0]  outdata;
    logic [2:0]   outsrc;
    logic         outvalid;
    logic         outready;
    logic [15:0]  count;

    logic         mode6;
    logic [2:0]   sel6;
    logic [95:0]  indata6;
    logic [5:0]   invalid6;
    logic [5:0]   inready6;
    logic [15:0]  outdata6;
    logic [2:0]   outsrc6;
    logic         outvalid6;
    logic         outready6;
    logic [15:0]  count6;

    logic [15:0]  chdata [8];

    int checks = 0;
    int errors = 0;

    bit          m_valid;
    logic [15:0] m_data;
    int          m_src;
    int          m_ptr;
    int          m_count;

    mux_arbiter #(.W(16), .N(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
        .indata(indata), .invalid(invalid), .inready(inready),
        .outdata(outdata), .outsrc(outsrc), .outvalid(outvalid),
        .outready(outready), .count(count)
    );

    mux_arbiter #(.W(16), .N(6)) u_dut6 (
        .clk(clk), .reset_n(reset_n), .mode(mode6), .sel(sel6),
        .indata(indata6), .invalid(invalid6), .inready(inready6),
        .outdata(outdata6), .outsrc(outsrc6), .outvalid(outvalid6),
        .outready(outready6), .count(count6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < 8; i++) indata[i*16 +: 16] = chdata[i];
    endtask

    // Candidate from the arbitration rules: fixed index, or first requester walking up from the pointer.
    function automatic void m_cand(input logic md, input logic [2:0] s, input logic [7:0] v,
                                   input int p, output bit f, output int c);
        f = 1'b0;
        c = 0;
        if (!md) begin
            if (v[s]) begin
                f = 1'b1;
                c = int'(s);
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (p + k) % 8;
                if (!f && v[idx[2:0]]) begin
                    f = 1'b1;
                    c = idx;
                end
            end
        end
    endfunction

    task automatic step();
        bit         f;
        bit         g;
        int         c;
        logic [7:0] er;
        #1;
        m_cand(mode, sel, invalid, m_ptr, f, c);
        g  = f && (!m_valid || outready);
        er = g ? 8'(1 << c) : 8'h00;
        check("inready", 32'(inready), 32'(er));
        @(posedge clk);
        if (g) begin
            m_data  = chdata[c];
            m_src   = c;
            m_valid = 1'b1;
            m_count = (m_count + 1) % 65536;
            if (mode) m_ptr = (c + 1) % 8;
        end else if (m_valid && outready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check("outvalid", 32'(outvalid), 32'(m_valid));
        check("outdata",  32'(outdata),  32'(m_data));
        check("outsrc",   32'(outsrc),   32'(m_src));
        check("count",    32'(count),    32'(m_count));
    endtask

    // Asserts reset away from any edge and checks the asynchronous clear before the next edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_outvalid", 32'(outvalid), 32'd0);
        check("rst_outdata",  32'(outdata),  32'd0);
        check("rst_outsrc",   32'(outsrc),   32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_inready",  32'(inready),  32'd0);
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = 0;
        m_count = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        invalid   = '0;
        outready  = 1'b0;
        mode6     = 1'b0;
        sel6      = '0;
        indata6   = '0;
        invalid6  = '0;
        outready6 = 1'b0;
        for (int i = 0; i < 8; i++) chdata[i] = 16'h1000 + 16'(i);
        drive_data();
        @(negedge clk);
        do_reset();

        // Fixed select of channel 5 with every channel requesting.
        mode = 1'b0; sel = 3'd5; invalid = 8'hFF; outready = 1'b1;
        repeat (6) step();

        // Round-robin over a sparse request set; pointer still 0 from the fixed phase.
        mode = 1'b1; invalid = 8'b1010_0101;
        repeat (8) step();

        // Backpressure: load channel 0, stall three cycles, then reload on the consuming edge.
        do_reset();
        invalid = 8'hFF; outready = 1'b0;
        repeat (4) step();
        outready = 1'b1;
        step();
        check("bp_reload_src", 32'(outsrc), 32'd1);

        // Drain: one word from channel 3, then nothing requests.
        mode = 1'b0; sel = 3'd3; invalid = 8'h08;
        step();
        invalid = 8'h00;
        repeat (2) step();
        check("drain_src", 32'(outsrc), 32'd3);

        // Random traffic, then an asynchronous reset while a word is held.
        repeat (400) begin
            mode     = 1'($urandom);
            sel      = 3'($urandom_range(0, 7));
            invalid  = 8'($urandom);
            outready = ($urandom % 4) != 0;
            for (int i = 0; i < 8; i++) chdata[i] = 16'($urandom);
            drive_data();
            step();
        end
        mode = 1'b1; invalid = 8'hFF; outready = 1'b0;
        step();
        check("pre_rst_valid", 32'(outvalid), 32'd1);
        do_reset();

        // Count wraps after 65536 transfers.
        mode = 1'b1; invalid = 8'hFF; outready = 1'b1;
        repeat (65535) step();
        check("count_max", 32'(count), 32'h0000FFFF);
        step();
        check("count_wrap", 32'(count), 32'd0);
        invalid = 8'h00;
        step();

        // Six-channel instance: select 7 names no channel, select 4 does.
        mode6 = 1'b0; sel6 = 3'd7; invalid6 = 6'h3F; outready6 = 1'b1;
        for (int i = 0; i < 6; i++) indata6[i*16 +: 16] = 16'h2000 + 16'(i);
        repeat (4) begin
            #1;
            check("n6_oor_inready", 32'(inready6), 32'd0);
            @(negedge clk);
            check("n6_oor_outvalid", 32'(outvalid6), 32'd0);
        end
        sel6 = 3'd4;
        #1;
        check("n6_sel4_inready", 32'(inready6), 32'h10);
        @(negedge clk);
        check("n6_sel4_outvalid", 32'(outvalid6), 32'd1);
        check("n6_sel4_outsrc", 32'(outsrc6), 32'd4);
        check("n6_sel4_outdata", 32'(outdata6), 32'h2004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
